// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  localparam int FWD_REGFILE = 0;

  // Must equal the REG_ADDR_W the controller is built with.
  localparam int META_RD_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [META_RD_W-1:0] rd;
    logic                 rd_we;
    logic                 is_load;
  } stage_meta_t;

endpackage

// File: rtl/pipe_meta_stage.sv
// One slot of the shadow pipeline: holds the metadata of the instruction in a stage.
module pipe_meta_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        bubble,
  input  stage_meta_t next_meta,
  output stage_meta_t meta_r
);

  // Bubble wins over load so a squashed slot never carries stale metadata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= '0;
    end else if (bubble) begin
      meta_r <= '0;
    end else if (load) begin
      meta_r <= next_meta;
    end else begin
      meta_r <= meta_r;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use/control hazard detection and EX operand forwarding for the in-order pipeline.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter  int NUM_STAGES = 5,
  parameter  int REG_ADDR_W = 5,
  localparam int FWD_W      = $clog2(NUM_STAGES - 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic                  ex_redirect,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic [FWD_W-1:0]      fwd_sel_rs1,
  output logic [FWD_W-1:0]      fwd_sel_rs2,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_flush_cnt
);

  localparam int NUM_META = NUM_STAGES - STG_EX;

  stage_meta_t           meta_r      [NUM_META];
  stage_meta_t           next_meta_s [NUM_META];
  logic [NUM_META-1:0]   bubble_s;
  logic                  luh_s;
  logic                  stall_s;
  logic                  ex_load_s;
  logic [REG_ADDR_W-1:0] ex_rs1_r;
  logic [REG_ADDR_W-1:0] ex_rs2_r;
  logic                  ex_uses_rs1_r;
  logic                  ex_uses_rs2_r;

  // A loaded result only exists after MEM, so a load sitting in MEM is never a source.
  function automatic logic can_fwd(stage_meta_t m, logic in_mem);
    return m.valid & m.rd_we & (m.rd != '0) & ~(in_mem & m.is_load);
  endfunction

  // Load-use detection; a redirect squashes the ID instruction so it never stalls.
  always_comb begin
    luh_s = id_valid & meta_r[0].valid & meta_r[0].is_load & (meta_r[0].rd != '0) &
            ((id_uses_rs1 & (id_rs1 == meta_r[0].rd)) |
             (id_uses_rs2 & (id_rs2 == meta_r[0].rd)));
    stall_s   = luh_s & ~ex_redirect;
    ex_load_s = id_valid & ~stall_s & ~ex_redirect;
  end

  assign stall_if = stall_s;
  assign stall_id = stall_s;
  assign flush_id = ex_redirect;
  assign flush_ex = luh_s | ex_redirect;

  for (genvar i = 0; i < NUM_META; i++) begin : g_meta
    if (i == 0) begin : g_ex
      assign next_meta_s[i] = '{valid: ex_load_s, rd: id_rd, rd_we: id_rd_we, is_load: id_is_load};
      assign bubble_s[i]    = ~ex_load_s;
    end else begin : g_post
      assign next_meta_s[i] = meta_r[i-1];
      assign bubble_s[i]    = 1'b0;
    end

    pipe_meta_stage u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (1'b1),
      .bubble    (bubble_s[i]),
      .next_meta (next_meta_s[i]),
      .meta_r    (meta_r[i])
    );
  end

  // Source-operand fields of the EX instruction; bubbles clear them so nothing forwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs1_r      <= '0;
      ex_rs2_r      <= '0;
      ex_uses_rs1_r <= 1'b0;
      ex_uses_rs2_r <= 1'b0;
    end else if (ex_load_s) begin
      ex_rs1_r      <= id_rs1;
      ex_rs2_r      <= id_rs2;
      ex_uses_rs1_r <= id_uses_rs1;
      ex_uses_rs2_r <= id_uses_rs2;
    end else begin
      ex_rs1_r      <= '0;
      ex_rs2_r      <= '0;
      ex_uses_rs1_r <= 1'b0;
      ex_uses_rs2_r <= 1'b0;
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwd_sel_rs1 = FWD_W'(FWD_REGFILE);
    fwd_sel_rs2 = FWD_W'(FWD_REGFILE);
    for (int s = NUM_STAGES - 1; s >= STG_MEM; s--) begin
      if (can_fwd(meta_r[s-STG_EX], s == STG_MEM) & ex_uses_rs1_r &
          (meta_r[s-STG_EX].rd == ex_rs1_r)) begin
        fwd_sel_rs1 = FWD_W'(s - STG_EX);
      end else begin
        fwd_sel_rs1 = fwd_sel_rs1;
      end
      if (can_fwd(meta_r[s-STG_EX], s == STG_MEM) & ex_uses_rs2_r &
          (meta_r[s-STG_EX].rd == ex_rs2_r)) begin
        fwd_sel_rs2 = FWD_W'(s - STG_EX);
      end else begin
        fwd_sel_rs2 = fwd_sel_rs2;
      end
    end
  end

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] flush_cnt_r;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
      flush_cnt_r <= 32'd0;
    end else begin
      stall_cnt_r <= stall_s     ? stall_cnt_r + 32'd1 : stall_cnt_r;
      flush_cnt_r <= ex_redirect ? flush_cnt_r + 32'd1 : flush_cnt_r;
    end
  end

  assign perf_stall_cnt = stall_cnt_r;
  assign perf_flush_cnt = flush_cnt_r;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a timeline model of in-flight instructions
// predicts each cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_pipe_hazard_ctrl;
  localparam int NS = 5;
  localparam int RW = 5;
  localparam int FW = $clog2(NS - 2);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_rd_we = 1'b0, id_is_load = 1'b0;
  logic          ex_redirect = 1'b0;
  logic          stall_if, stall_id, flush_id, flush_ex;
  logic [FW-1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic [31:0]   perf_stall_cnt, perf_flush_cnt;

  pipe_hazard_ctrl #(.NUM_STAGES(NS), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .stall_if(stall_if), .stall_id(stall_id),
    .flush_id(flush_id), .flush_ex(flush_ex), .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // An instruction that entered EX at cycle 'enter' is in stage 2 + (cyc - enter).
  typedef struct {
    int            enter;
    logic [RW-1:0] rd, rs1, rs2;
    bit            we, ld, u1, u2;
  } inst_t;

  typedef struct {
    bit          sif, sid, fid, fex;
    int          f1, f2;
    logic [31:0] ps, pf;
  } exp_t;

  inst_t       flight[$];
  exp_t        sbq[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] n_stall = 32'd0, n_flush = 32'd0;
  bit          last_stall = 1'b0;

  function automatic int fwd_of(logic [RW-1:0] rs, bit use_rs);
    int best = -1;
    int k = 0;
    foreach (flight[i]) begin
      int stg;
      stg = 2 + cyc - flight[i].enter;
      if (use_rs && stg >= 3 && stg <= NS - 1 && flight[i].we && flight[i].rd != 0 &&
          flight[i].rd == rs && !(stg == 3 && flight[i].ld) && flight[i].enter > best) begin
        best = flight[i].enter;
        k = stg - 2;
      end
    end
    return k;
  endfunction

  task automatic step(bit v, logic [RW-1:0] rs1, logic [RW-1:0] rs2, bit u1, bit u2,
                      logic [RW-1:0] rd, bit we, bit ld, bit redir);
    exp_t  e;
    inst_t x;
    bit    have_ex, luh;
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_rd_we = we; id_is_load = ld; ex_redirect = redir;
    while (flight.size() > 0 && 2 + cyc - flight[0].enter > NS - 1) void'(flight.pop_front());
    have_ex = flight.size() > 0 && flight[flight.size()-1].enter == cyc;
    x = have_ex ? flight[flight.size()-1] : '{0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0};
    luh = v && have_ex && x.ld && x.rd != 0 && ((u1 && rs1 == x.rd) || (u2 && rs2 == x.rd));
    e.sif = luh && !redir;
    e.sid = e.sif;
    e.fid = redir;
    e.fex = luh || redir;
    e.f1  = have_ex ? fwd_of(x.rs1, x.u1) : 0;
    e.f2  = have_ex ? fwd_of(x.rs2, x.u2) : 0;
`ifdef PIPE_PERF_EN
    e.ps = n_stall;
    e.pf = n_flush;
`else
    e.ps = 32'd0;
    e.pf = 32'd0;
`endif
    sbq.push_back(e);
    if (e.sif) n_stall++;
    if (redir) n_flush++;
    last_stall = e.sif;
    if (v && !e.sif && !redir) flight.push_back('{cyc + 1, rd, rs1, rs2, we, ld, u1, u2});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    cyc++;
    rst_n = 1'b0;
    id_valid = 1'b0; ex_redirect = 1'b0;
    flight.delete();
    n_stall = 32'd0; n_flush = 32'd0; last_stall = 1'b0;
    sbq.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'd0, 32'd0});
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", nm, act, req, cyc);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("stall_if", 32'(stall_if), 32'(e.sif));
        chk("stall_id", 32'(stall_id), 32'(e.sid));
        chk("flush_id", 32'(flush_id), 32'(e.fid));
        chk("flush_ex", 32'(flush_ex), 32'(e.fex));
        chk("fwd_sel_rs1", 32'(fwd_sel_rs1), 32'(e.f1));
        chk("fwd_sel_rs2", 32'(fwd_sel_rs2), 32'(e.f2));
        chk("perf_stall_cnt", perf_stall_cnt, e.ps);
        chk("perf_flush_cnt", perf_flush_cnt, e.pf);
      end
    end
  end

  initial begin : stimulus
    logic [RW-1:0] r1, r2, rd;
    bit v, u1, u2, we, ld, rdr;
    do_reset();
    // reset with three producers in flight; x5 must not forward afterwards
    step(1, 0, 0, 0, 0, 5, 1, 0, 0);
    step(1, 0, 0, 0, 0, 6, 1, 0, 0);
    step(1, 0, 0, 0, 0, 7, 1, 0, 0);
    do_reset();
    step(1, 5, 0, 1, 0, 9, 1, 0, 0);
    idle(2);
    // back-to-back ALU at distance 1 and 2
    step(1, 1, 2, 1, 1, 5, 1, 0, 0);
    step(1, 5, 6, 1, 1, 7, 1, 0, 0);
    idle(1);
    step(1, 1, 2, 1, 1, 5, 1, 0, 0);
    idle(1);
    step(1, 5, 6, 1, 1, 7, 1, 0, 0);
    idle(3);
    // load-use: one stall, then the held instruction enters EX
    step(1, 2, 0, 1, 0, 6, 1, 1, 0);
    step(1, 6, 1, 1, 1, 8, 1, 0, 0);
    step(1, 6, 1, 1, 1, 8, 1, 0, 0);
    idle(3);
    // x0 never forwards and a load to x0 never stalls
    step(1, 0, 0, 1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 1, 9, 1, 0, 0);
    idle(1);
    step(1, 1, 0, 1, 0, 0, 1, 1, 0);
    step(1, 0, 0, 1, 1, 9, 1, 0, 0);
    idle(3);
    // redirect concurrent with a load-use match
    step(1, 2, 0, 1, 0, 6, 1, 1, 0);
    step(1, 6, 1, 1, 1, 8, 1, 0, 1);
    idle(3);
    // three load-use stalls and two redirects from a clean reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 2, 0, 1, 0, 6, 1, 1, 0);
      step(1, 3, 6, 0, 1, 8, 1, 0, 0);
      step(1, 3, 6, 0, 1, 8, 1, 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 1, 4, 1, 0, 1);
    idle(3);
    // randomized traffic over a small register set to provoke hazards
    v = 0; r1 = '0; r2 = '0; rd = '0; u1 = 0; u2 = 0; we = 0; ld = 0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        if (!last_stall) begin
          v  = $urandom_range(0, 3) != 0;
          r1 = RW'($urandom_range(0, 3));
          r2 = RW'($urandom_range(0, 3));
          rd = RW'($urandom_range(0, 3));
          u1 = $urandom_range(0, 1) == 1;
          u2 = $urandom_range(0, 1) == 1;
          we = $urandom_range(0, 3) != 0;
          ld = $urandom_range(0, 2) == 0;
        end
        rdr = $urandom_range(0, 7) == 0;
        step(v, r1, r2, u1, u2, rd, we, ld, rdr);
      end
    end
    idle(2);
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
